// File: rtl/pwm_pkg.sv
// Shared PWM link definitions: duty codes and the duty high-time table.
// The PWM generator and the decoder both derive their numbers from here,
// so the duty table exists in one place only.
package pwm_pkg;

  typedef enum logic [1:0] {
    DUTY_0   = 2'd0,
    DUTY_75  = 2'd1,
    DUTY_875 = 2'd2,
    DUTY_99  = 2'd3
  } duty_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } dec_state_e;

  // High time in clocks for a duty code at period n (integer division).
  function automatic int duty_high(input duty_e code, input int n);
    case (code)
      DUTY_0:   return 0;
      DUTY_75:  return n * 75 / 100;
      DUTY_875: return n * 875 / 1000;
      default:  return n * 99 / 100;
    endcase
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous input, plus rise/fall pulses
// derived from the synchronised level. Reusable for any async input.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;

  // Shift the async input through the synchroniser chain; keep one extra
  // delayed copy of the synchronised level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync[0] <= i_async;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_dly <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = o_sync & ~r_dly;
  assign o_fall = ~o_sync & r_dly;

endmodule

// File: rtl/pwm_duty_decoder.sv
// PWM receive decoder: measures period and high time between rising edges
// of the synchronised input, classifies the high time into a duty code,
// and flags out-of-tolerance periods and stuck-high inputs.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no period open; watchdog counts low time for code-0 timeout
// ST_MEASURE | period open since last rise; counting period and high time
module pwm_duty_decoder #(
  parameter int N           = 256,
  parameter int TOL         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwm_in,
  output logic [1:0] duty_cycle,
  output logic       duty_valid,
  output logic       locked,
  output logic       period_err
);
  import pwm_pkg::*;

  localparam int CW = $clog2(2 * N);
  localparam int H1 = duty_high(DUTY_75, N);
  localparam int H2 = duty_high(DUTY_875, N);
  localparam int H3 = duty_high(DUTY_99, N);

  localparam logic [CW-1:0] T1      = CW'(H1 / 2);
  localparam logic [CW-1:0] T2      = CW'((H1 + H2) / 2);
  localparam logic [CW-1:0] T3      = CW'((H2 + H3) / 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(2 * N - 1);
  // Timeout fires on the cycle whose increment would reach 2N-1, so that
  // with a restart at 0 the code-0 report repeats every 2N-1 cycles.
  localparam logic [CW-1:0] CNT_TO  = CW'(2 * N - 2);
  localparam logic [CW-1:0] P_MIN   = CW'(N - TOL);
  localparam logic [CW-1:0] P_MAX   = CW'(N + TOL);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  function automatic duty_e classify(input logic [CW-1:0] high);
    if (high < T1) return DUTY_0;
    if (high < T2) return DUTY_75;
    if (high < T3) return DUTY_875;
    return DUTY_99;
  endfunction

  logic w_pwm_s;
  logic w_rise;
  logic w_fall;
  logic w_unused_fall;

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (reset),
    .i_async (pwm_in),
    .o_sync  (w_pwm_s),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Falling edges carry no information for duty decoding.
  assign w_unused_fall = w_fall;

  dec_state_e    r_state;
  logic [CW-1:0] r_period_cnt;
  logic [CW-1:0] r_high_cnt;
  duty_e         r_duty;
  logic          r_valid;
  logic          r_locked;
  logic          r_err;

  dec_state_e    w_state_nxt;
  logic [CW-1:0] w_period_nxt;
  logic [CW-1:0] w_high_nxt;
  duty_e         w_duty_nxt;
  logic          w_valid_nxt;
  logic          w_locked_nxt;
  logic          w_err_nxt;

  logic [CW-1:0] w_period_inc;
  logic [CW-1:0] w_high_inc;
  logic          w_timeout;
  logic          w_period_ok;

  assign w_period_inc = (r_period_cnt == CNT_MAX) ? r_period_cnt : r_period_cnt + CNT_ONE;
  assign w_high_inc   = (r_high_cnt == CNT_MAX) ? r_high_cnt : r_high_cnt + CNT_ONE;
  assign w_timeout    = (r_period_cnt >= CNT_TO);
  assign w_period_ok  = (r_period_cnt >= P_MIN) && (r_period_cnt <= P_MAX);

  // Next-state, counter and output decision; a rise always takes priority
  // over a coincident timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_period_nxt = r_period_cnt;
    w_high_nxt   = r_high_cnt;
    w_duty_nxt   = r_duty;
    w_valid_nxt  = 1'b0;
    w_locked_nxt = r_locked;
    w_err_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_high_nxt = '0;
        if (w_rise) begin
          w_state_nxt  = ST_MEASURE;
          w_period_nxt = CNT_ONE;
          w_high_nxt   = CNT_ONE;
        end else if (w_pwm_s) begin
          w_period_nxt = '0;
        end else if (w_timeout) begin
          w_duty_nxt   = DUTY_0;
          w_valid_nxt  = 1'b1;
          w_locked_nxt = 1'b1;
          w_period_nxt = '0;
        end else begin
          w_period_nxt = w_period_inc;
        end
      end

      ST_MEASURE: begin
        if (w_rise) begin
          w_period_nxt = CNT_ONE;
          w_high_nxt   = CNT_ONE;
          if (w_period_ok) begin
            w_duty_nxt   = classify(r_high_cnt);
            w_valid_nxt  = 1'b1;
            w_locked_nxt = 1'b1;
          end else begin
            w_err_nxt    = 1'b1;
            w_locked_nxt = 1'b0;
          end
        end else if (w_timeout) begin
          w_state_nxt  = ST_IDLE;
          w_period_nxt = '0;
          w_high_nxt   = '0;
          if (w_pwm_s) begin
            w_err_nxt    = 1'b1;
            w_locked_nxt = 1'b0;
          end else begin
            w_duty_nxt   = DUTY_0;
            w_valid_nxt  = 1'b1;
            w_locked_nxt = 1'b1;
          end
        end else begin
          w_period_nxt = w_period_inc;
          if (w_pwm_s) begin
            w_high_nxt = w_high_inc;
          end
        end
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_period_nxt = '0;
        w_high_nxt   = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_duty       <= DUTY_0;
      r_valid      <= 1'b0;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_period_cnt <= w_period_nxt;
      r_high_cnt   <= w_high_nxt;
      r_duty       <= w_duty_nxt;
      r_valid      <= w_valid_nxt;
      r_locked     <= w_locked_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign duty_cycle = r_duty;
  assign duty_valid = r_valid;
  assign locked     = r_locked;
  assign period_err = r_err;

endmodule
